// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Decoupled fetch stage. It issues sequential word addresses to the
// instruction memory and collects the in-order responses in a small prefetch
// queue. The core receives {instruction, pc} through a valid/ready handshake.
// A redirect flushes the queue, marks every in-flight fetch for discard and
// restarts fetch at the new PC.
//
// Parameters
//   RESET_PC : first fetch address after reset (word aligned)
//   DEPTH    : prefetch queue entries (power of two, >= 2); also the limit on
//              queued plus in-flight fetches
//
// Ports
//   clock, reset          : clock, asynchronous active-low reset
//   redirect_valid/_pc    : restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_req_valid/_ready : fetch request handshake, address on imem_req_addr
//   imem_rsp_valid/_data  : in-order response, no backpressure
//   inst_valid/_ready     : queue head handshake towards the core
//   inst_out, inst_pc     : head instruction and its PC (zero when empty)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);  // queue pointer width
    localparam int CW = PW + 1;         // holds 0..DEPTH
    localparam int SW = PW + 2;         // count + outstanding without overflow

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    // State
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    // Queue storage: plain arrays without reset; validity is tracked by count_q.
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic          req_fire;
    logic          push;
    logic          pop;
    logic [SW-1:0] credit_sum;
    logic [31:0]   redirect_target;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[31:2], 2'b00};

    // Every slot that is queued or already promised to an in-flight fetch
    // consumes one credit, so a response can never find the queue full.
    assign credit_sum = {1'b0, count_q} + {1'b0, outstanding_q};

    // Gated with reset so no request escapes while reset is held low.
    assign imem_req_valid = reset && !redirect_valid && (credit_sum < DEPTH_S);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid = (count_q != '0);
    assign inst_out   = inst_valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]    : 32'h0;

    // A redirect cancels both queue operations of its cycle.
    assign pop  = inst_valid && inst_ready && !redirect_valid;
    assign push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

    always_comb begin
        fetch_pc_d    = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d      = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        count_d       = count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        drop_d        = drop_q;
        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still in flight after this cycle's response belongs
            // to the old path; this cycle's response is discarded as well.
            drop_d     = outstanding_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= rsp_pc_q;
            instr_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

    // A push into a full queue without a simultaneous pop means the credit
    // accounting is broken.
    a_no_queue_overflow: assert property (
        @(posedge clock) disable iff (!reset)
        !(push && !pop && (count_q == DEPTH_C))
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Randomized bench for instruction_fetch_unit. A behavioural memory with
// random in-order latency answers the requests. The reference model tracks
// the instruction stream as queues: requests in flight (tagged with the
// redirect epoch they were issued in) and instructions the core should see.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    always #5 clock = ~clock;

    instruction_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        logic [31:0] pc;        // address the model expects for this fetch
        logic [31:0] dut_addr;  // address actually presented by the DUT
        int          due;       // cycle in which the memory answers
        int          epoch;     // redirect epoch the fetch was issued in
    } req_t;

    req_t        pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    logic [31:0] exp_fetch = RST_PC;
    int          lat_min = 1, lat_max = 1;
    int          p_ready = 100, p_iready = 100, p_redir = 0;
    bit          force_redir = 0;
    logic [31:0] force_rp = 32'h0;
    bit          verbose = 1;
    int          pops = 0;
    int          n_acc = 0;
    int          first_valid_cyc = 0;
    bit          cap_armed = 0;
    bit          cap_done = 0;
    logic [31:0] cap_pc = 32'h0;
    bit          chk_next = 0;
    bit          last_rsp_pop = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: called at a falling edge, drives inputs, checks the
    // outputs, advances the model and returns at the next falling edge.
    task automatic step();
        req_t        e;
        bit          redir;
        bit          do_pop;
        logic [31:0] rp;
        int          due;
        cyc++;
        redir = force_redir || (int'($urandom_range(99)) < p_redir);
        rp    = force_redir ? force_rp : $urandom;
        force_redir    = 0;
        redirect_valid = redir;
        redirect_pc    = rp;
        imem_req_ready = (int'($urandom_range(99)) < p_ready);
        inst_ready     = (int'($urandom_range(99)) < p_iready);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].dut_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        expect_eq("inst_valid", 32'(inst_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            expect_eq("inst_pc", inst_pc, exp_q[0]);
            expect_eq("inst_out", inst_out, mem_word(exp_q[0]));
        end
        expect_eq("req_valid", 32'(imem_req_valid),
                  32'(!redir && (exp_q.size() + pend.size() < DEPTH)));
        if (imem_req_valid) expect_eq("req_addr", imem_req_addr, exp_fetch);
        if (chk_next) begin
            expect_eq("redirect_next_req_valid", 32'(imem_req_valid), 32'd1);
            expect_eq("redirect_next_req_addr", imem_req_addr, 32'h0000_0200);
            chk_next = 0;
        end
        last_rsp_pop = redir && imem_rsp_valid && inst_valid && inst_ready;
        if (first_valid_cyc == 0 && inst_valid) first_valid_cyc = cyc;

        do_pop = !redir && (exp_q.size() > 0) && inst_ready;
        if (do_pop) begin
            pops++;
            pop_log.push_back(inst_pc);
            if (cap_armed) begin
                cap_pc    = inst_pc;
                cap_done  = 1;
                cap_armed = 0;
            end
            if (verbose) $display("cycle %0d: consumed pc=%08h instr=%08h", cyc, inst_pc, inst_out);
            void'(exp_q.pop_front());
        end
        if (imem_rsp_valid) begin
            e = pend.pop_front();
            if (!redir && e.epoch == epoch) exp_q.push_back(e.pc);
        end
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{pc: exp_fetch, dut_addr: imem_req_addr, due: due, epoch: epoch});
            exp_fetch = exp_fetch + 32'd4;
            n_acc++;
        end
        if (redir) begin
            epoch++;
            exp_q.delete();
            exp_fetch = {rp[31:2], 2'b00};
        end
        @(negedge clock);
    endtask

    // Called at a falling edge: asserts reset between clock edges, so the
    // outputs must clear without waiting for a rising edge.
    task automatic apply_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pend.delete();
        exp_q.delete();
        epoch++;
        exp_fetch = RST_PC;
        #1;
        expect_eq("reset_inst_valid", 32'(inst_valid), 32'd0);
        expect_eq("reset_req_valid", 32'(imem_req_valid), 32'd0);
        expect_eq("reset_inst_pc", inst_pc, 32'h0);
        expect_eq("reset_inst_out", inst_out, 32'h0);
        repeat (2) @(negedge clock);
        reset           = 1'b1;
        cyc             = 0;
        last_due        = 0;
        first_valid_cyc = 0;
    endtask

    initial begin
        int pops0;
        @(negedge clock);
        apply_reset();

        // Back-to-back stream from reset, wrapping through address zero.
        lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 100; p_redir = 0;
        pop_log.delete();
        repeat (20) step();
        expect_eq("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        expect_eq("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
        expect_eq("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
        expect_eq("wrap_pc2", pop_log[2], 32'h0000_0000);
        expect_eq("full_rate_pops", 32'(pops), 32'd18);

        // Core stalls: fetch stops at the credit limit, then drains in order.
        p_iready = 0;
        n_acc = 0;
        repeat (10) step();
        expect_eq("stall_accepts_bounded", 32'(n_acc <= DEPTH), 32'd1);
        expect_eq("stall_queue_full", 32'(inst_valid), 32'd1);
        p_iready = 100;
        pops0 = pops;
        repeat (12) step();
        expect_eq("drain_pops", 32'(pops - pops0 >= DEPTH), 32'd1);

        // Redirect with several fetches in flight at 3-cycle latency.
        lat_min = 3; lat_max = 3;
        repeat (12) step();
        force_redir = 1; force_rp = 32'h0000_0100;
        cap_armed = 1; cap_done = 0;
        step();
        repeat (15) step();
        expect_eq("redirect_captured", 32'(cap_done), 32'd1);
        expect_eq("redirect_first_pc", cap_pc, 32'h0000_0100);

        // Redirect colliding with a response and a pop, unaligned target.
        lat_min = 1; lat_max = 1;
        repeat (6) step();
        force_redir = 1; force_rp = 32'h0000_0203;
        step();
        expect_eq("redirect_rsp_pop_same_cycle", 32'(last_rsp_pop), 32'd1);
        chk_next = 1;
        repeat (8) step();

        // Randomized traffic.
        verbose = 0;
        for (int blk = 0; blk < 15; blk++) begin
            lat_min  = 1;
            lat_max  = int'($urandom_range(5, 1));
            p_ready  = int'($urandom_range(100, 30));
            p_iready = int'($urandom_range(100, 20));
            p_redir  = int'($urandom_range(8, 0));
            repeat (200) step();
        end

        // Reset in the middle of traffic with queued and in-flight fetches.
        verbose = 1;
        lat_min = 3; lat_max = 3; p_ready = 100; p_iready = 0; p_redir = 0;
        repeat (20) step();
        for (int i = 0; i < 40 && !(exp_q.size() >= 2 && pend.size() >= 2); i++) step();
        expect_eq("midop_queue_loaded", 32'(inst_valid), 32'd1);
        apply_reset();
        lat_min = 1; lat_max = 1; p_iready = 100;
        repeat (20) step();
        expect_eq("post_reset_first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        expect_eq("enough_traffic", 32'(pops >= 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
